// File: rtl/daq_dma_arbiter.sv
// daq_dma_arbiter: packet-atomic round-robin arbiter merging NSRC event-buffer streams onto one DMA stream.
// Define DAQ_ARB_STATS_EN to build the per-source saturating packet counters; otherwise pkt_count is tied to 0.
module daq_dma_arbiter #(
    parameter int NSRC = 4,
    parameter int DW   = 64
) (
    input  logic                 dma_clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [NSRC-1:0]      src_mask,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [NSRC*DW-1:0]   src_data,
    input  logic [NSRC-1:0]      src_last,
    output logic [NSRC-1:0]      src_ready,
    output logic                 dma_valid,
    output logic [DW-1:0]        dma_data,
    output logic                 dma_last,
    input  logic                 dma_ready,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic [NSRC*16-1:0]   pkt_count,
    input  logic                 stat_clear
);
    typedef enum logic {IDLE, PASS} state_t;

    state_t          state_q, state_d;
    logic [2:0]      grant_q, grant_d;
    logic [2:0]      last_q, last_d;
    logic [NSRC-1:0] req;
    logic            pass;
    logic            done;

    assign req      = src_valid & src_mask;
    assign pass     = reset_n && (state_q == PASS);
    assign done     = pass && dma_valid && dma_ready && dma_last;
    assign busy     = pass;
    assign grant_id = grant_q;

    // Steer the granted source onto the DMA stream; everything is quiet outside PASS or in reset.
    always_comb begin
        src_ready = '0;
        dma_valid = 1'b0;
        dma_data  = '0;
        dma_last  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (pass && grant_q == 3'(i)) begin
                src_ready[i] = dma_ready;
                dma_valid    = src_valid[i];
                dma_data     = src_data[DW*i +: DW];
                dma_last     = src_last[i];
            end
        end
    end

    // Idle: pick the first requester after last_grant; Pass: hold the grant until the last beat transfers.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (enable && |req) begin
                state_d = PASS;
                for (int k = NSRC; k >= 1; k--) begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (i == (int'(last_q) + k) % NSRC && req[i]) grant_d = 3'(i);
                    end
                end
            end
        end else if (done) begin
            state_d = IDLE;
            last_d  = grant_q;
        end
    end

    // State, grant and round-robin pointer; the pointer starts at NSRC-1 so source 0 wins first.
    always_ff @(posedge dma_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 3'(NSRC - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef DAQ_ARB_STATS_EN
    logic [NSRC*16-1:0] cnt_q, cnt_d;

    // Saturating per-source completed-packet counters; a clear beats a coincident increment.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NSRC; i++) begin
            if (done && grant_q == 3'(i) && cnt_q[16*i +: 16] != 16'hFFFF)
                cnt_d[16*i +: 16] = cnt_q[16*i +: 16] + 16'd1;
        end
        if (stat_clear) cnt_d = '0;
    end

    // Counter register.
    always_ff @(posedge dma_clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign pkt_count = cnt_q;
`else
    logic unused_stat_clear;

    assign unused_stat_clear = stat_clear;
    assign pkt_count         = '0;
`endif
endmodule
